// File: rtl/bht_update_scheduler_if.sv
// Interface for the BHT update scheduler: the EXE update handshake, the clear request
// and the BHT write port.
interface bht_update_scheduler_if #(
  parameter int SIZE_OF_INDEX = 7,
  parameter int ENTRY_W       = 56,
  parameter int QUEUE_DEPTH   = 4
);
  // Handshake: an update transfers on a cycle where upd_valid && upd_ready at the rising clk
  // edge; upd_valid and its payload stay stable until that transfer happens; upd_ready never
  // depends on upd_valid.
  logic                               upd_valid;
  logic                               upd_ready;
  logic [SIZE_OF_INDEX-1:0]           upd_index;
  logic [ENTRY_W-1:0]                 upd_data;
  logic                               clr_req;
  logic                               wr_grant;
  logic                               wr_en;
  logic [SIZE_OF_INDEX-1:0]           wr_addr;
  logic [ENTRY_W-1:0]                 wr_data;
  logic                               bpu_en;
  logic [$clog2(QUEUE_DEPTH):0]       q_count;
  logic                               dbg_state;

  modport master (
    output upd_valid, upd_index, upd_data, clr_req, wr_grant,
    input  upd_ready, wr_en, wr_addr, wr_data, bpu_en, q_count, dbg_state
  );

  modport slave (
    input  upd_valid, upd_index, upd_data, clr_req, wr_grant,
    output upd_ready, wr_en, wr_addr, wr_data, bpu_en, q_count, dbg_state
  );
endinterface

// File: rtl/bht_update_scheduler.sv
// BHT write-port owner: queues EXE updates in a FIFO and sequences full-table clears.
// Optional macro BHT_UPD_COALESCE_EN merges an update into the youngest entry on index match.
module bht_update_scheduler #(
  parameter int SIZE_OF_INDEX = 7,
  parameter int ENTRY_W       = 56,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  bht_update_scheduler_if.slave  bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [SIZE_OF_INDEX-1:0] ptr_q, ptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            rd_q, wr_q, young;
  logic [SIZE_OF_INDEX-1:0] idx_mem  [QUEUE_DEPTH];
  logic [ENTRY_W-1:0]       data_mem [QUEUE_DEPTH];

  logic                     full, empty, ready, xfer, pop, push, coal, match;
  logic                     wr_en;
  logic [SIZE_OF_INDEX-1:0] wr_addr;
  logic [ENTRY_W-1:0]       wr_data;

  assign full  = (cnt_q == CW'(QUEUE_DEPTH));
  assign empty = (cnt_q == '0);
  assign young = wr_q - AW'(1);

`ifdef BHT_UPD_COALESCE_EN
  assign match = !empty && (idx_mem[young] == bus.upd_index);
  assign ready = !full || match;
`else
  assign match = 1'b0;
  assign ready = !full;
`endif

  assign xfer = bus.upd_valid && ready;
  assign pop  = (state_q == S_RUN) && !empty && bus.wr_grant;
  // A lone entry that is leaving this cycle cannot absorb the update; it enqueues instead.
  assign coal = (state_q == S_RUN) && xfer && match && !bus.clr_req &&
                !((cnt_q == CW'(1)) && pop);
  assign push = (state_q == S_RUN) && xfer && !bus.clr_req && !coal;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_CLEAR: begin
        wr_en   = bus.wr_grant;
        wr_addr = ptr_q;
        cnt_d   = '0;
        if (bus.clr_req) begin
          ptr_d = '0;
        end else if (bus.wr_grant) begin
          ptr_d = ptr_q + SIZE_OF_INDEX'(1);
          if (&ptr_q) state_d = S_RUN;
        end
      end
      S_RUN: begin
        wr_en = pop;
        if (!empty) begin
          wr_addr = idx_mem[rd_q];
          wr_data = data_mem[rd_q];
        end
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_RUN) && bus.clr_req) begin
        rd_q <= '0;
        wr_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + AW'(1);
        if (pop)  rd_q <= rd_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read while the occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wr_q]  <= bus.upd_index;
      data_mem[wr_q] <= bus.upd_data;
    end
    if (coal) begin
      data_mem[young] <= bus.upd_data;
    end
  end

  assign bus.upd_ready = ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_addr;
  assign bus.wr_data   = wr_data;
  assign bus.bpu_en    = (state_q == S_RUN);
  assign bus.q_count   = cnt_q;
  assign bus.dbg_state = state_q;
endmodule
